// File: rtl/neural_layer_if.sv
// neural_layer_if: load, control and status bus of the sequential neural layer
interface neural_layer_if #(parameter int DW = 8, parameter int N_NEU = 4);
  logic data_valid;
  logic [DW-1:0] data_in;
  logic changes;
  logic keep_params;
  logic act_mode;
  logic busy;
  logic done;
  logic err;
  logic [N_NEU*DW-1:0] network_outputs;
  modport master (output data_valid, data_in, changes, keep_params, act_mode,
                  input busy, done, err, network_outputs);
  modport slave (input data_valid, data_in, changes, keep_params, act_mode,
                 output busy, done, err, network_outputs);
endinterface

// File: rtl/neural_layer_seq.sv
// neural_layer_seq: byte-serially loaded fully-connected layer, one shared MAC per cycle
module neural_layer_seq #(
  parameter int N_IN = 4,
  parameter int N_NEU = 4,
  parameter int DW = 8,
  parameter int SHIFT = 0,
  parameter int ACC_W = 2*DW + $clog2(N_IN+1)
) (
  input logic clk,
  input logic reset,
  neural_layer_if.slave bus
);
  typedef enum logic [1:0] {LOAD_X, LOAD_P, COMPUTE} state_t;
  localparam int PP = N_NEU*(N_IN+2);
  localparam int CW = $clog2(PP+1);
  localparam int IW = $clog2(N_IN+1);
  localparam int KW = $clog2(N_NEU+1);
  localparam int PW = $clog2(N_IN+2);
  localparam logic [ACC_W-1:0] SAT = {{(ACC_W-DW){1'b0}}, {DW{1'b1}}};
  state_t state;
  logic [CW-1:0] cnt, cnt_n, exp_n;
  logic ovf, ovf_n, take, good, pvalid, mode, busy, done, err;
  logic [PW-1:0] pos;
  logic [KW-1:0] nrn, ck;
  logic [IW-1:0] idx;
  logic [N_IN*DW-1:0] xv;
  logic [N_NEU*N_IN*DW-1:0] wv;
  logic [N_NEU*DW-1:0] bv, tv, stage, stage_n, outs;
  logic [ACC_W-1:0] acc, acc_n, thx, diff;
  logic [2*DW-1:0] prod;
  logic [DW-1:0] act;
  int lk, lp, ci, mi;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.err = err;
  assign bus.network_outputs = outs;
  always_comb begin
    exp_n = state == LOAD_X ? CW'(N_IN) : CW'(PP);
    take = bus.data_valid && cnt != exp_n;
    cnt_n = cnt + CW'(take);
    ovf_n = ovf | (bus.data_valid & ~take);
    good = cnt_n == exp_n && !ovf_n;
    lk = N_NEU - 1 - int'(nrn);
    lp = int'(pos);
    ci = int'(ck);
    mi = int'(idx) == N_IN ? 0 : int'(idx);
    prod = wv[(ci*N_IN + mi)*DW +: DW] * xv[mi*DW +: DW];
    acc_n = (idx == '0 ? ACC_W'(bv[ci*DW +: DW]) : acc) + ACC_W'(prod);
    thx = ACC_W'(tv[ci*DW +: DW]);
    diff = (acc - thx) >> SHIFT;
    act = !(acc > thx) ? '0 : !mode ? DW'(1) : diff > SAT ? '1 : diff[DW-1:0];
    stage_n = stage;
    stage_n[ci*DW +: DW] = act;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_X;
      cnt <= '0;
      ovf <= 1'b0;
      pvalid <= 1'b0;
      mode <= 1'b0;
      pos <= '0;
      nrn <= '0;
      ck <= '0;
      idx <= '0;
      xv <= '0;
      wv <= '0;
      bv <= '0;
      tv <= '0;
      acc <= '0;
      stage <= '0;
      outs <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        COMPUTE: begin
          if (int'(idx) == N_IN) begin
            stage <= stage_n;
            idx <= '0;
            ck <= ck + 1'b1;
            if (ci == N_NEU-1) begin
              outs <= stage_n;
              done <= 1'b1;
              busy <= 1'b0;
              ck <= '0;
              state <= LOAD_X;
            end
          end else begin
            acc <= acc_n;
            idx <= idx + 1'b1;
          end
        end
        default: begin
          cnt <= cnt_n;
          ovf <= ovf_n;
          if (take && state == LOAD_X) xv[(N_IN-1-int'(cnt))*DW +: DW] <= bus.data_in;
          // parameter stream per neuron: th, b, then weights highest input first
          if (take && state == LOAD_P) begin
            if (lp == 0) tv[lk*DW +: DW] <= bus.data_in;
            else if (lp == 1) bv[lk*DW +: DW] <= bus.data_in;
            else wv[(lk*N_IN + N_IN + 1 - lp)*DW +: DW] <= bus.data_in;
            pos <= lp == N_IN+1 ? '0 : pos + 1'b1;
            nrn <= lp == N_IN+1 ? nrn + 1'b1 : nrn;
          end
          if (bus.changes) begin
            cnt <= '0;
            ovf <= 1'b0;
            pos <= '0;
            nrn <= '0;
            if (!good || (state == LOAD_X && bus.keep_params && !pvalid)) err <= 1'b1;
            else if (state == LOAD_X && !bus.keep_params) state <= LOAD_P;
            else begin
              state <= COMPUTE;
              busy <= 1'b1;
              pvalid <= 1'b1;
              mode <= bus.act_mode;
              ck <= '0;
              idx <= '0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_neural_layer_seq.sv
// tb_neural_layer_seq: scoreboard bench driving a SHIFT=0 and a SHIFT=2 layer in lockstep
module tb_neural_layer_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  neural_layer_if #(.DW(8), .N_NEU(4)) bus ();
  neural_layer_if #(.DW(8), .N_NEU(4)) bus2 ();
  assign bus2.data_valid = bus.data_valid;
  assign bus2.data_in = bus.data_in;
  assign bus2.changes = bus.changes;
  assign bus2.keep_params = bus.keep_params;
  assign bus2.act_mode = bus.act_mode;
  neural_layer_seq #(.N_IN(4), .N_NEU(4), .DW(8), .SHIFT(0)) dut (.clk(clk), .reset(reset), .bus(bus));
  neural_layer_seq #(.N_IN(4), .N_NEU(4), .DW(8), .SHIFT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  typedef struct {
    logic [31:0] o1;
    logic [31:0] o2;
    int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, cyc = 0, bc = 0, errs = 0;
  localparam logic [31:0] RA = {8'd140, 8'd105, 8'd70, 8'd35};
  localparam logic [31:0] RA2 = {8'd35, 8'd26, 8'd17, 8'd8};
  localparam logic [31:0] RB = {8'd1, 8'd1, 8'd0, 8'd0};
  localparam logic [31:0] RC = {8'd40, 8'd5, 8'd0, 8'd0};
  localparam logic [31:0] RC2 = {8'd10, 8'd1, 8'd0, 8'd0};
  localparam logic [31:0] RE = {8'd20, 8'd15, 8'd10, 8'd5};
  localparam logic [31:0] RE2 = {8'd5, 8'd3, 8'd2, 8'd1};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask
  // monitor: counts err pulses and busy cycles, pops the scoreboard on every done
  always @(negedge clk) begin
    if (reset) bc = 0;
    else begin
      if (bus.err) errs++;
      if (bus.busy) bc++;
      if (bus.done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_shift0", bus.network_outputs, e.o1);
          chk("out_shift2", bus2.network_outputs, e.o2);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", bc, 20);
          chk("done_shift2", {31'd0, bus2.done}, 1);
        end
        bc = 0;
      end
    end
  end
  task automatic word(input logic [7:0] d, input bit chg);
    bus.data_valid = 1'b1;
    bus.data_in = d;
    bus.changes = chg;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.changes = 1'b0;
  endtask
  task automatic load_x(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    word(a, 0);
    word(b, 0);
    word(c, 0);
    word(d, 0);
  endtask
  task automatic load_p(input logic [7:0] th, input bit sat);
    logic [7:0] v;
    for (int k = 3; k >= 0; k--) begin
      v = sat ? 8'd255 : 8'(k + 1);
      word(th, 0);
      word(v, 0);
      repeat (4) word(v, 0);
    end
  endtask
  task automatic pulse(input bit keep, input bit act, input bit push, input logic [31:0] o1, input logic [31:0] o2);
    bus.changes = 1'b1;
    bus.keep_params = keep;
    bus.act_mode = act;
    if (push) q.push_back('{o1, o2, cyc + 21});
    @(posedge clk);
    #1;
    bus.changes = 1'b0;
    bus.keep_params = 1'b0;
  endtask
  task automatic wait_done();
    for (int n = 0; n < 60 && q.size() != 0; n++) @(posedge clk);
    #1;
    chk("done_timeout", q.size(), 0);
    q.delete();
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.data_valid = 1'b0;
    bus.data_in = '0;
    bus.changes = 1'b0;
    bus.keep_params = 1'b0;
    bus.act_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_out", bus.network_outputs, 0);
    chk("reset_out2", bus2.network_outputs, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    load_x(8'd1, 8'd2, 8'd3, 8'd4);
    pulse(1, 1, 0, 0, 0);
    idle(2);
    chk("err_keep_no_params", errs, 1);
    chk("busy_keep_no_params", bus.busy, 0);
    chk("out_keep_no_params", bus.network_outputs, 0);
    load_x(8'd10, 8'd9, 8'd8, 8'd7);
    pulse(0, 0, 0, 0, 0);
    load_p(8'd0, 0);
    pulse(0, 1, 1, RA, RA2);
    wait_done();
    chk("err_after_relu_run", errs, 1);
    load_x(8'd1, 8'd1, 8'd1, 8'd1);
    pulse(1, 1, 1, RE, RE2);
    wait_done();
    word(8'd3, 0);
    word(8'd3, 0);
    word(8'd3, 0);
    pulse(0, 1, 0, 0, 0);
    idle(2);
    chk("err_short_x", errs, 2);
    chk("out_short_x", bus.network_outputs, RE);
    repeat (5) word(8'd5, 0);
    pulse(0, 1, 0, 0, 0);
    idle(2);
    chk("err_long_x", errs, 3);
    chk("out_long_x", bus.network_outputs, RE);
    chk("busy_long_x", bus.busy, 0);
    word(8'd10, 0);
    word(8'd9, 0);
    word(8'd8, 0);
    word(8'd7, 1);
    load_p(8'd100, 0);
    pulse(0, 0, 1, RB, RB);
    wait_done();
    load_x(8'd10, 8'd9, 8'd8, 8'd7);
    pulse(1, 1, 1, RC, RC2);
    wait_done();
    chk("err_after_th100", errs, 3);
    load_x(8'd255, 8'd255, 8'd255, 8'd255);
    pulse(0, 0, 0, 0, 0);
    load_p(8'd0, 1);
    pulse(0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    load_x(8'd10, 8'd9, 8'd8, 8'd7);
    pulse(0, 0, 0, 0, 0);
    load_p(8'd0, 0);
    pulse(0, 1, 0, 0, 0);
    idle(5);
    chk("busy_mid_compute", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_out", bus.network_outputs, 0);
    chk("abort_out2", bus2.network_outputs, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    load_x(8'd10, 8'd9, 8'd8, 8'd7);
    pulse(0, 0, 0, 0, 0);
    load_p(8'd0, 0);
    pulse(0, 1, 1, RA, RA2);
    idle(3);
    bus.changes = 1'b1;
    bus.keep_params = 1'b1;
    bus.act_mode = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in = 8'd99;
    @(posedge clk);
    #1;
    bus.changes = 1'b0;
    bus.keep_params = 1'b0;
    bus.data_valid = 1'b0;
    wait_done();
    idle(30);
    chk("final_err_count", errs, 3);
    chk("final_busy", bus.busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
